// File: rtl/uart_tx_ctrl_if.sv
// Producer write port, status flags and the TX engine handshake of uart_tx_ctrl.
// The slave modport is the controller; the master modport is the producer plus engine side.
interface uart_tx_ctrl_if #(
  parameter int DEPTH = 8
);
  logic                     enable;
  logic                     wr_valid;
  logic [7:0]               wr_data;
  logic                     wr_ready;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     tx_idle;
  logic                     ovf;
  logic                     ovf_clr;
  logic                     eng_start;
  logic [7:0]               eng_data;
  logic                     eng_busy;
  logic                     eng_baud_en;
  logic                     baud_tick;

  modport master (
    output enable, wr_valid, wr_data, ovf_clr, eng_busy, eng_baud_en,
    input  wr_ready, fifo_count, tx_idle, ovf, eng_start, eng_data, baud_tick
  );

  modport slave (
    input  enable, wr_valid, wr_data, ovf_clr, eng_busy, eng_baud_en,
    output wr_ready, fifo_count, tx_idle, ovf, eng_start, eng_data, baud_tick
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Byte FIFO feeding a UART TX engine through an IDLE/LAUNCH/WAIT_DONE handshake,
// plus the baud strobe generator the engine runs from while it is sending.
module uart_tx_ctrl #(
  parameter int CLK_DIV = 434,
  parameter int DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave bus
);
  localparam int              AW        = $clog2(DEPTH);
  localparam int              CW        = $clog2(CLK_DIV);
  localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      data_q;
  logic            ovf_q;
  logic [CW-1:0]   baud_cnt;
  logic            push, pop;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never frees room for a write; that write is dropped and flagged.
  assign bus.wr_ready   = (count != FULL_CNT);
  assign push           = bus.wr_valid && bus.wr_ready;
  assign bus.fifo_count = count;
  assign bus.ovf        = ovf_q;
  assign bus.eng_data   = data_q;
  assign bus.eng_start  = (state == LAUNCH);
  assign bus.tx_idle    = (count == '0) && (state == IDLE);
  assign bus.baud_tick  = bus.eng_baud_en && (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      if (pop) data_q <= mem[rd_ptr];
      if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end else if (bus.wr_valid && !bus.wr_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Enable only gates new pops; a byte already launched runs to completion.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && (count != '0) && !bus.eng_busy) begin
          pop     = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH:    state_n = WAIT_DONE;
      WAIT_DONE: if (!bus.eng_busy) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.eng_baud_en) begin
      baud_cnt <= '0;
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end
endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, clk cycles per baud bit (legal 2..65535).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  permits draining the FIFO to the engine.
REQ-006 SHALL have port wr_valid  input  1  producer byte-write request.
REQ-007 SHALL have port wr_data  input  8  producer byte.
REQ-008 SHALL have port wr_ready  output  1  FIFO not full.
REQ-009 SHALL have port fifo_count  output  $clog2(DEPTH)+1  bytes queued.
REQ-010 SHALL have port tx_idle  output  1  FIFO empty and FSM in IDLE.
REQ-011 SHALL have port ovf  output  1  sticky overflow flag.
REQ-012 SHALL have port ovf_clr  input  1  clears ovf.
REQ-013 SHALL have port eng_start  output  1  start request to TX engine (e_bus).
REQ-014 SHALL have port eng_data  output  8  byte to TX engine.
REQ-015 SHALL have port eng_busy  input  1  TX engine busy.
REQ-016 SHALL have port eng_baud_en  input  1  TX engine requests baud ticks.
REQ-017 SHALL have port baud_tick  output  1  one-cycle baud strobe to TX engine.

Function
REQ-018 FIFO push SHALL occur when wr_valid && wr_ready; wr_ready = (fifo_count != DEPTH), from registered count only.
REQ-019 Write while full SHALL be dropped and set ovf next cycle; ovf held until ovf_clr (ovf_clr wins over simultaneous set).
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-021 No bypass: a byte pushed into an empty FIFO SHALL be poppable no earlier than the following cycle.
REQ-022 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE.
REQ-023 IDLE: if enable && fifo_count!=0 && !eng_busy, pop head into eng_data register, go LAUNCH; else stay.
REQ-024 LAUNCH: eng_start=1 for exactly this one cycle; go WAIT_DONE unconditionally.
REQ-025 WAIT_DONE: eng_start=0; return to IDLE on first cycle eng_busy==0.
REQ-026 eng_data SHALL change only on a pop and stay stable from LAUNCH until the next pop.
REQ-027 Deasserting enable SHALL not abort a launched byte; it only blocks new pops.
REQ-028 Baud counter SHALL run 0..CLK_DIV-1 only while eng_baud_en=1, and be forced to 0 in any cycle eng_baud_en=0.
REQ-029 baud_tick SHALL be 1 for one cycle when counter==CLK_DIV-1, i.e. first tick CLK_DIV cycles after eng_baud_en rises, then every CLK_DIV cycles.
REQ-030 Minimum gap between consecutive eng_start pulses SHALL be 3 cycles (LAUNCH, ≥1 WAIT_DONE, IDLE).

Reset
REQ-031 On rst: FSM=IDLE, pointers=0, fifo_count=0, wr_ready=1, tx_idle=1, ovf=0, eng_start=0, eng_data=8'h00, baud counter=0, baud_tick=0.
REQ-032 rst mid-frame SHALL discard queued bytes and the in-flight byte; no eng_start in the cycle after rst deasserts.
REQ-033 rst SHALL take priority over all other inputs in the same cycle.

Verification (CLK_DIV=4, DEPTH=8, engine model attached)
REQ-034 Push 8'h55 with enable=1 -> one eng_start pulse, eng_data=8'h55, line shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first, stop) at 4-cycle bits, tx_idle=1 afterwards.
REQ-035 Push 9 bytes back-to-back with enable=0 -> 9th dropped, wr_ready=0, fifo_count=8, ovf=1; ovf_clr -> ovf=0.
REQ-036 Queue 8'hA0,8'hA1,8'hA2, enable=1 -> three frames in order, eng_start pulses separated by frame time, fifo_count 3->0.
REQ-037 Full FIFO, simultaneous pop and wr_valid -> write rejected, ovf=1, fifo_count=7 next cycle.
REQ-038 eng_baud_en toggles 1->0->1 -> counter restarts, first tick exactly 4 cycles after re-rise.
REQ-039 rst asserted in WAIT_DONE with 3 bytes queued -> all REQ-031 values next cycle, no further eng_start.
